// File: rtl/reg_writeback_pkg.sv
`default_nettype none
// ---- reg_writeback_pkg : shared types for the writeback stage ---- rev 1.0 ----
package reg_writeback_pkg;
  localparam int BLOCK_W  = 16;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 16;

  typedef logic [BLOCK_W-1:0] block_t;
  typedef logic [ADDR_W-1:0]  reg_addr_t;

  typedef struct packed {
    reg_addr_t addr;
    block_t    value;
  } wb_req_t;
endpackage
`default_nettype wire

// File: rtl/reg_writeback_fifo.sv
`default_nettype none
// ---- wb_fifo : pending-write FIFO; exposes entries head-first for forwarding -- rev 1.0 ----
module wb_fifo
  import reg_writeback_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  wb_req_t                    i_push_data,
  input  logic                       i_pop,
  output wb_req_t                    o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(BUF_DEPTH):0] o_count,
  output wb_req_t                    o_entries [BUF_DEPTH],
  output logic [BUF_DEPTH-1:0]       o_valid
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

  wb_req_t       r_mem [BUF_DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CW'(BUF_DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  // Index 0 is the head (oldest); higher indices are progressively younger.
  always_comb begin
    for (int i = 0; i < BUF_DEPTH; i++) begin
      o_entries[i] = r_mem[r_rd_ptr + PW'(i)];
      o_valid[i]   = (CW'(i) < r_count);
    end
  end
endmodule
`default_nettype wire

// File: rtl/reg_writeback.sv
`default_nettype none
// ---- reg_writeback : writeback stage, 16-entry register file, ordered commit -- rev 1.0 ----
// ---- optional WB_DUMP_EN: register dump on falling do_halt ----
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int WIDTH     = BLOCK_W,
  parameter int NREGS     = NUM_REGS,
  parameter int BUF_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             do_halt,
  input  logic             do_mem_reg_write,
  input  logic [3:0]       mem_reg_addr,
  input  logic [WIDTH-1:0] mem_value,
  input  logic             exe_reg_write,
  input  logic [3:0]       exe_reg_addr,
  input  logic [WIDTH-1:0] exe_value,
  input  logic [3:0]       rd_addr1,
  input  logic [3:0]       rd_addr2,
  output logic [WIDTH-1:0] rd_data1,
  output logic [WIDTH-1:0] rd_data2,
  output logic             wb_stall,
  output logic             wb_idle
);
  logic [WIDTH-1:0] r_regs [NREGS];

  wb_req_t                    w_head;
  wb_req_t                    w_entries [BUF_DEPTH];
  logic [BUF_DEPTH-1:0]       w_valid;
  logic                       w_full;
  logic                       w_empty;
  logic [$clog2(BUF_DEPTH):0] w_unused_count;

  logic             w_exe_ok;
  logic             w_direct;
  logic             w_push;
  logic             w_pop;
  logic             w_wr_en;
  reg_addr_t        w_wr_addr;
  logic [WIDTH-1:0] w_wr_data;

  // Writes to R0 are discarded outright; a stalled exe request is dropped.
  assign w_exe_ok = exe_reg_write && (exe_reg_addr != '0) && !w_full;

  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = mem_reg_addr;
    w_wr_data = mem_value;
    w_pop     = 1'b0;
    w_direct  = 1'b0;
    if (do_mem_reg_write) begin
      w_wr_en = (mem_reg_addr != '0);
    end else if (!w_empty) begin
      w_pop     = 1'b1;
      w_wr_en   = 1'b1;
      w_wr_addr = w_head.addr;
      w_wr_data = WIDTH'(w_head.value);
    end else if (w_exe_ok) begin
      w_direct  = 1'b1;
      w_wr_en   = 1'b1;
      w_wr_addr = exe_reg_addr;
      w_wr_data = exe_value;
    end
  end

  assign w_push = w_exe_ok && !w_direct;

  wb_fifo #(
    .BUF_DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data ({exe_reg_addr, block_t'(exe_value)}),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_unused_count),
    .o_entries   (w_entries),
    .o_valid     (w_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[w_wr_addr] <= w_wr_data;
    end
  end

  // Age order, oldest first: array, current mem, FIFO head..tail, current exe.
  function automatic logic [WIDTH-1:0] f_forward(input reg_addr_t a);
    logic [WIDTH-1:0] v;
    v = r_regs[a];
    if (do_mem_reg_write && (mem_reg_addr == a)) v = mem_value;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      if (w_valid[i] && (w_entries[i].addr == a)) v = WIDTH'(w_entries[i].value);
    end
    if (w_exe_ok && (exe_reg_addr == a)) v = exe_value;
    if (a == '0) v = '0;
    return v;
  endfunction

  always_comb begin
    rd_data1 = f_forward(rd_addr1);
    rd_data2 = f_forward(rd_addr2);
  end

  assign wb_stall = w_full;
  assign wb_idle  = w_empty && !do_mem_reg_write && !exe_reg_write;

  a_no_exe_when_stalled: assert property (@(posedge clk) disable iff (!rst)
    !(exe_reg_write && wb_stall));

`ifdef WB_DUMP_EN
  always @(negedge do_halt) begin
    $display("----------------------------------------");
    for (int i = 0; i < NREGS; i++) begin
      $display("reg[%2d]: %d", i, f_forward(reg_addr_t'(i)));
    end
  end
`else
  logic w_unused_halt;
  assign w_unused_halt = do_halt;
`endif
endmodule
`default_nettype wire

// File: tb/tb_reg_writeback.sv
`default_nettype none
// ---- tb_reg_writeback : scoreboard bench for reg_writeback -- rev 1.0 ----
module tb_reg_writeback;
  import reg_writeback_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        do_halt = 1'b0;
  logic        do_mem_reg_write = 1'b0;
  logic [3:0]  mem_reg_addr = '0;
  logic [15:0] mem_value = '0;
  logic        exe_reg_write = 1'b0;
  logic [3:0]  exe_reg_addr = '0;
  logic [15:0] exe_value = '0;
  logic [3:0]  rd_addr1 = '0;
  logic [3:0]  rd_addr2 = '0;
  logic [15:0] rd_data1;
  logic [15:0] rd_data2;
  logic        wb_stall;
  logic        wb_idle;

  reg_writeback dut (
    .clk              (clk),
    .rst              (rst),
    .do_halt          (do_halt),
    .do_mem_reg_write (do_mem_reg_write),
    .mem_reg_addr     (mem_reg_addr),
    .mem_value        (mem_value),
    .exe_reg_write    (exe_reg_write),
    .exe_reg_addr     (exe_reg_addr),
    .exe_value        (exe_value),
    .rd_addr1         (rd_addr1),
    .rd_addr2         (rd_addr2),
    .rd_data1         (rd_data1),
    .rd_data2         (rd_data2),
    .wb_stall         (wb_stall),
    .wb_idle          (wb_idle)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    reg_addr_t a;
    block_t    d;
  } ent_t;

  // Model: committed array, pending exe queue, expected commit scoreboard.
  block_t arr [16];
  ent_t   exe_q[$];
  ent_t   commit_q[$];
  ent_t   pend_c;
  ent_t   pend_e;
  ent_t   mon_c;
  ent_t   tmp_e;
  bit     pend_v, pend_pop, pend_push;
  bit     exp_stall, exp_idle, exp_exe_ok;

  task automatic model_flush();
    exe_q.delete();
    commit_q.delete();
    pend_v = 0; pend_pop = 0; pend_push = 0;
    exp_exe_ok = 0;
    for (int i = 0; i < 16; i++) arr[i] = '0;
  endtask

  task automatic model_apply();
    if (pend_pop) tmp_e = exe_q.pop_front();
    if (pend_v) arr[pend_c.a] = pend_c.d;
    if (pend_push) exe_q.push_back(pend_e);
    pend_v = 0; pend_pop = 0; pend_push = 0;
  endtask

  function automatic block_t exp_fwd(input reg_addr_t a);
    block_t v;
    if (a == '0) return '0;
    v = arr[a];
    if (do_mem_reg_write && mem_reg_addr == a) v = mem_value;
    foreach (exe_q[i]) if (exe_q[i].a == a) v = exe_q[i].d;
    if (exp_exe_ok && exe_reg_addr == a) v = exe_value;
    return v;
  endfunction

  // One cycle: drive after the edge, predict its commit, return at the negedge.
  task automatic step(input bit mv, input logic [3:0] ma, input logic [15:0] md,
                      input bit ev, input logic [3:0] ea, input logic [15:0] ed);
    @(posedge clk);
    #3;
    model_apply();
    do_mem_reg_write = mv; mem_reg_addr = ma; mem_value = md;
    exe_reg_write = ev; exe_reg_addr = ea; exe_value = ed;
    exp_stall  = (exe_q.size() == DEPTH);
    exp_idle   = (exe_q.size() == 0) && !mv && !ev;
    exp_exe_ok = ev && (ea != 0) && !exp_stall;
    if (mv) begin
      pend_v = (ma != 0);
      pend_c = '{ma, md};
    end else if (exe_q.size() > 0) begin
      pend_pop = 1; pend_v = 1;
      pend_c = exe_q[0];
    end else if (exp_exe_ok) begin
      pend_v = 1;
      pend_c = '{ea, ed};
    end
    pend_push = exp_exe_ok && (mv || exe_q.size() > 0);
    pend_e = '{ea, ed};
    if (pend_v) commit_q.push_back(pend_c);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    if (rst && commit_q.size() > 0) begin
      mon_c = commit_q.pop_front();
      n_checks++;
      if (dut.r_regs[mon_c.a] !== mon_c.d)
        $display("FAIL commit_r%0d: got %h want %h", mon_c.a, dut.r_regs[mon_c.a], mon_c.d);
      else n_pass++;
    end
  end

  task automatic test_reset();
    rd_addr1 = 4'd3; rd_addr2 = 4'd0;
    repeat (2) @(posedge clk);
    #2;
    n_checks++; if (wb_stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", wb_stall); else n_pass++;
    n_checks++; if (wb_idle !== 1'b1) $display("FAIL reset_idle: got %b want 1", wb_idle); else n_pass++;
    n_checks++; if (rd_data1 !== 16'd0) $display("FAIL reset_rd: got %h want 0", rd_data1); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_mem_only();
    rd_addr1 = 4'd3;
    step(1, 4'd3, 16'd10, 0, 4'd0, 16'd0);
    n_checks++; if (rd_data1 !== 16'd10) $display("FAIL memonly_fwd: got %0d want 10", rd_data1); else n_pass++;
    n_checks++; if (wb_idle !== 1'b0) $display("FAIL memonly_busy: got %b want 0", wb_idle); else n_pass++;
    step(0, 4'd0, 16'd0, 0, 4'd0, 16'd0);
    n_checks++; if (rd_data1 !== 16'd10) $display("FAIL memonly_rd: got %0d want 10", rd_data1); else n_pass++;
    n_checks++; if (wb_idle !== 1'b1) $display("FAIL memonly_idle: got %b want 1", wb_idle); else n_pass++;
  endtask

  task automatic test_mem_exe();
    rd_addr1 = 4'd6; rd_addr2 = 4'd5;
    step(1, 4'd5, 16'd7, 1, 4'd6, 16'd9);
    n_checks++; if (rd_data1 !== 16'd9) $display("FAIL memexe_fwd6: got %0d want 9", rd_data1); else n_pass++;
    n_checks++; if (rd_data2 !== 16'd7) $display("FAIL memexe_fwd5: got %0d want 7", rd_data2); else n_pass++;
    step(0, 4'd0, 16'd0, 0, 4'd0, 16'd0);
    n_checks++; if (dut.r_regs[6] !== 16'd0) $display("FAIL memexe_r6_early: got %0d want 0", dut.r_regs[6]); else n_pass++;
    n_checks++; if (rd_data1 !== 16'd9) $display("FAIL memexe_fifo_fwd: got %0d want 9", rd_data1); else n_pass++;
    n_checks++; if (wb_idle !== 1'b0) $display("FAIL memexe_busy: got %b want 0", wb_idle); else n_pass++;
    step(0, 4'd0, 16'd0, 0, 4'd0, 16'd0);
    n_checks++; if (dut.r_regs[6] !== 16'd9) $display("FAIL memexe_r6: got %0d want 9", dut.r_regs[6]); else n_pass++;
    n_checks++; if (wb_idle !== 1'b1) $display("FAIL memexe_idle: got %b want 1", wb_idle); else n_pass++;
  endtask

  task automatic test_collision();
    rd_addr1 = 4'd4;
    step(1, 4'd4, 16'd1, 1, 4'd4, 16'd2);
    n_checks++; if (rd_data1 !== 16'd2) $display("FAIL coll_c0: got %0d want 2", rd_data1); else n_pass++;
    step(0, 4'd0, 16'd0, 0, 4'd0, 16'd0);
    n_checks++; if (rd_data1 !== 16'd2) $display("FAIL coll_c1: got %0d want 2", rd_data1); else n_pass++;
    n_checks++; if (dut.r_regs[4] !== 16'd1) $display("FAIL coll_memfirst: got %0d want 1", dut.r_regs[4]); else n_pass++;
    step(0, 4'd0, 16'd0, 0, 4'd0, 16'd0);
    n_checks++; if (rd_data1 !== 16'd2) $display("FAIL coll_c2: got %0d want 2", rd_data1); else n_pass++;
  endtask

  task automatic test_back_to_back();
    rd_addr1 = 4'd2; rd_addr2 = 4'd8;
    step(1, 4'd1, 16'h0011, 1, 4'd2, 16'h0022);
    n_checks++; if (wb_stall !== 1'b0) $display("FAIL b2b_stall0: got %b want 0", wb_stall); else n_pass++;
    step(1, 4'd2, 16'h0033, 1, 4'd8, 16'h0044);
    n_checks++; if (rd_data1 !== 16'h0022) $display("FAIL b2b_fifo_over_mem: got %h want 0022", rd_data1); else n_pass++;
    n_checks++; if (rd_data2 !== 16'h0044) $display("FAIL b2b_exe_fwd: got %h want 0044", rd_data2); else n_pass++;
    step(1, 4'd9, 16'h0055, 0, 4'd0, 16'd0);
    n_checks++; if (wb_stall !== 1'b1) $display("FAIL b2b_full: got %b want 1", wb_stall); else n_pass++;
    step(0, 4'd0, 16'd0, 0, 4'd0, 16'd0);
    n_checks++; if (wb_stall !== exp_stall) $display("FAIL b2b_drain1: got %b want %b", wb_stall, exp_stall); else n_pass++;
    step(0, 4'd0, 16'd0, 0, 4'd0, 16'd0);
    n_checks++; if (wb_stall !== 1'b0) $display("FAIL b2b_stall_fall: got %b want 0", wb_stall); else n_pass++;
    step(0, 4'd0, 16'd0, 0, 4'd0, 16'd0);
    n_checks++; if (wb_idle !== exp_idle) $display("FAIL b2b_idle: got %b want %b", wb_idle, exp_idle); else n_pass++;
    n_checks++; if (rd_data1 !== 16'h0022) $display("FAIL b2b_final_r2: got %h want 0022", rd_data1); else n_pass++;
    n_checks++; if (rd_data2 !== 16'h0044) $display("FAIL b2b_final_r8: got %h want 0044", rd_data2); else n_pass++;
    rd_addr1 = 4'd1; rd_addr2 = 4'd9;
    step(0, 4'd0, 16'd0, 0, 4'd0, 16'd0);
    n_checks++; if (rd_data1 !== exp_fwd(4'd1)) $display("FAIL b2b_final_r1: got %h want %h", rd_data1, exp_fwd(4'd1)); else n_pass++;
    n_checks++; if (rd_data2 !== 16'h0055) $display("FAIL b2b_final_r9: got %h want 0055", rd_data2); else n_pass++;
  endtask

  task automatic test_r0();
    rd_addr1 = 4'd0; rd_addr2 = 4'd0;
    step(0, 4'd0, 16'd0, 1, 4'd0, 16'd55);
    n_checks++; if (rd_data1 !== 16'd0) $display("FAIL r0_fwd: got %0d want 0", rd_data1); else n_pass++;
    do_halt = 1'b1;
    step(0, 4'd0, 16'd0, 0, 4'd0, 16'd0);
    do_halt = 1'b0;
    n_checks++; if (wb_idle !== 1'b1) $display("FAIL r0_not_queued: got %b want 1", wb_idle); else n_pass++;
    n_checks++; if (dut.r_regs[0] !== 16'd0) $display("FAIL r0_array: got %0d want 0", dut.r_regs[0]); else n_pass++;
  endtask

  task automatic test_reset_mid_drain();
    step(1, 4'd10, 16'h00A1, 1, 4'd11, 16'h00B1);
    step(1, 4'd12, 16'h00A2, 1, 4'd13, 16'h00B2);
    @(posedge clk);
    #3;
    do_mem_reg_write = 0; exe_reg_write = 0;
    mem_reg_addr = '0; exe_reg_addr = '0; mem_value = '0; exe_value = '0;
    n_checks++; if (wb_stall !== 1'b1) $display("FAIL rstmid_full: got %b want 1", wb_stall); else n_pass++;
    rd_addr1 = 4'd10; rd_addr2 = 4'd11;
    rst = 1'b0;
    model_flush();
    #1;
    n_checks++; if (wb_stall !== 1'b0) $display("FAIL rstmid_stall: got %b want 0", wb_stall); else n_pass++;
    n_checks++; if (rd_data1 !== 16'd0) $display("FAIL rstmid_r10: got %h want 0", rd_data1); else n_pass++;
    n_checks++; if (rd_data2 !== 16'd0) $display("FAIL rstmid_r11: got %h want 0", rd_data2); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    rd_addr1 = 4'd13; rd_addr2 = 4'd11;
    repeat (3) step(0, 4'd0, 16'd0, 0, 4'd0, 16'd0);
    n_checks++; if (rd_data1 !== 16'd0) $display("FAIL rstmid_r13_late: got %h want 0", rd_data1); else n_pass++;
    n_checks++; if (dut.r_regs[11] !== 16'd0) $display("FAIL rstmid_r11_late: got %h want 0", dut.r_regs[11]); else n_pass++;
    n_checks++; if (wb_idle !== 1'b1) $display("FAIL rstmid_idle: got %b want 1", wb_idle); else n_pass++;
  endtask

  initial begin
    model_flush();
    test_reset();
    test_mem_only();
    test_mem_exe();
    test_collision();
    test_back_to_back();
    test_r0();
    test_reset_mid_drain();
    repeat (2) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
endmodule
`default_nettype wire
